// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin byte scheduler feeding a UART transmitter, one fixed-length slot per byte.
// Grants and the start pulse are decoded from state so a byte is accepted in the same cycle it is seen.
module uart_tx_sched #(
  parameter int UART_BPS = 9600,
  parameter int clk_fre  = 50_000_000,
  parameter int GAP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       gnt1,
  output logic [7:0] pi_data,
  output logic       pi_sig,
  output logic       busy,
  output logic       done
);
  localparam int BAUD_CNT_MAX = clk_fre / UART_BPS;
  localparam int SLOT_CYC = BAUD_CNT_MAX * (10 + GAP_BITS);
  localparam logic [19:0] CNT_LOAD = 20'(SLOT_CYC - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t      r_state, w_next;
  logic [19:0] r_cnt;
  logic [7:0]  r_data;
  logic        r_last;
  logic        w_go, w_win1;

  always_comb begin
    w_go   = (r_state == IDLE) && en && (req0 || req1) && rst_n;
    w_win1 = req1 && (!req0 || !r_last);
    gnt0   = w_go && !w_win1;
    gnt1   = w_go && w_win1;
    pi_sig = r_state == START;
    busy   = r_state != IDLE;
    done   = (r_state == WAIT) && (r_cnt == 20'd0);
    w_next = w_go ? START : (r_state == START) ? WAIT : done ? IDLE : r_state;
  end

  // Pointer resets to 1 so requester 0 wins the first contested grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 20'd0;
      r_data  <= 8'h00;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_data <= w_win1 ? data1 : data0;
        r_last <= w_win1;
      end
      if (r_state == START) r_cnt <= CNT_LOAD;
      else if (r_state == WAIT && r_cnt != 20'd0) r_cnt <= r_cnt - 20'd1;
    end
  end

  assign pi_data = r_data;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: random and directed stimulus checked against a slot-timing reference model.
module tb_uart_tx_sched;
  localparam int SLOT = 110;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic gnt0, gnt1, pi_sig, busy, done;
  logic [7:0] pi_data;

  int n_cmp = 0, n_bad = 0;
  int m_t = 0, m_last = 1, m_win = 0;
  logic [7:0] m_data = 8'h00;
  logic m_go;
  int gnt_seen = 0;

  uart_tx_sched #(.UART_BPS(1), .clk_fre(10), .GAP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req0(req0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .data1(data1), .gnt1(gnt1),
    .pi_data(pi_data), .pi_sig(pi_sig), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // m_t counts cycles since the grant cycle; 0 means free to grant.
  task automatic cycle(input logic r, input logic e, input logic q0, input logic [7:0] d0,
                       input logic q1, input logic [7:0] d1);
    @(negedge clk);
    rst_n = r; en = e; req0 = q0; data0 = d0; req1 = q1; data1 = d1;
    #1;
    if (!r) begin
      m_t = 0; m_last = 1; m_data = 8'h00;
    end
    m_go  = r && e && (q0 || q1) && m_t == 0;
    m_win = (q0 && q1) ? 1 - m_last : (q1 ? 1 : 0);
    chk("gnt0", gnt0, m_go && m_win == 0);
    chk("gnt1", gnt1, m_go && m_win == 1);
    chk("pi_sig", pi_sig, m_t == 1);
    chk("busy", busy, m_t >= 1);
    chk("done", done, m_t == SLOT + 1);
    chk("pi_data", pi_data, m_data);
    if (gnt0 || gnt1) gnt_seen++;
    @(posedge clk);
    if (r) begin
      if (m_go) begin
        m_t = 1; m_last = m_win; m_data = m_win ? d1 : d0;
      end else if (m_t == SLOT + 1) m_t = 0;
      else if (m_t > 0) m_t++;
    end
  endtask

  initial begin
    logic q0, q1, e, r;
    logic [7:0] d0, d1;
    int rst_left;
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 8'hA5, 0, 8'h00);
    for (int i = 0; i < 120; i++) cycle(1, 1, 1, 8'hA5, 0, 8'h00);
    for (int i = 0; i < 460; i++) cycle(1, 1, 1, 8'h11, 1, 8'h22);
    for (int i = 0; i < 150; i++) cycle(1, 0, 0, 8'h00, 1, 8'h22);
    cycle(1, 1, 0, 8'h00, 1, 8'h22);
    for (int i = 0; i < 52; i++) cycle(1, 1, 1, 8'h3C, 0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 8'h3C, 0, 8'h00);
    for (int i = 0; i < 60; i++) cycle(1, 1, 1, 8'h3C, (i > 5), 8'h77);
    for (int i = 0; i < 120; i++) cycle(1, 1, 0, 8'hFF, 0, 8'h00);
    q0 = 0; q1 = 0; e = 1; d0 = 0; d1 = 0; rst_left = 0;
    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(7) == 0) q0 = ~q0;
      if ($urandom_range(7) == 0) q1 = ~q1;
      if ($urandom_range(15) == 0) e = ~e;
      if ($urandom_range(3) == 0) d0 = 8'($urandom);
      if ($urandom_range(3) == 0) d1 = 8'($urandom);
      if (rst_left == 0 && $urandom_range(2999) == 0) rst_left = 1 + $urandom_range(3);
      r = rst_left == 0;
      if (rst_left > 0) rst_left--;
      cycle(r, e, q0, d0, q1, d1);
    end
    chk("grants_seen", gnt_seen > 20, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
